// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Holds the buffered long-latency result entry, parameter defaults and a
// small helper that turns a destination register number into a pending mask.
package wb_pkg;

  localparam int RD_W   = 5;
  localparam int DATA_W = 32;

  // Defaults for the arbiter parameters.
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_STARVE_MAX = 4;

  // One buffered long-latency result: destination register plus write data.
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot mask over registers x1..x31; x0 maps to an empty mask so that
  // callers never need a separate zero check before touching the scoreboard.
  function automatic logic [31:1] rd_mask(input logic [RD_W-1:0] rd);
    logic [31:1] m;
    m = '0;
    if (rd != '0) m = 31'd1 << (rd - 5'd1);
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Purpose: synchronous buffer for long-latency results awaiting a regfile slot.
// Latency: an entry pushed on one edge is visible at head from the next cycle.
// Backpressure: full/empty flags; a push while full succeeds only with a same-cycle pop.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset (empties the buffer)
//   push, push_data - write one entry on the rising edge
//   pop             - drop the head entry on the rising edge (ignored when empty)
//   head            - current oldest entry (undefined while empty)
//   full, empty     - occupancy flags, derived from registered state only
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH   // power of two, at least 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one the head is leaving this
  // cycle; the head is read combinationally before the edge, so no hazard.
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: stale data is never visible because the
  // occupancy count gates every use of the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Purpose: shares the single regfile write port between the core writeback and a
//          buffered long-latency unit, and keeps the pending-register scoreboard.
// Latency: core path 0 cycles (combinational); LU results reach the regfile no
//          earlier than the cycle after acceptance, in arrival order.
// Backpressure: lu_ready drops when the buffer is full; stall_o asks the core to
//          hold its writeback once the buffer has lost STARVE_MAX arbitrations.
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   wb_valid/wb_rd/wb_data        - core writeback request (single cycle)
//   lu_valid/lu_ready/lu_rd/lu_data - long-latency result, valid/ready handshake
//   iss_valid/iss_rd              - long-latency issue, marks rd pending
//   chk_rs1/rs2/rd, busy_rs1/rs2/rd - hazard query against the scoreboard
//   stall_o                       - core must hold its writeback this cycle
//   rf_we/rf_waddr/rf_wdata       - register-file write port
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [RD_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [RD_W-1:0]   lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  input  logic              iss_valid,
  input  logic [RD_W-1:0]   iss_rd,
  input  logic [RD_W-1:0]   chk_rs1,
  input  logic [RD_W-1:0]   chk_rs2,
  input  logic [RD_W-1:0]   chk_rd,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              busy_rd,
  output logic              stall_o,
  output logic              rf_we,
  output logic [RD_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  wb_entry_t     push_entry;
  wb_entry_t     head;

  logic [SW-1:0] starve_cnt;
  logic          core_win;

  logic [31:1]   pending;
  logic [31:0]   pend_vec;
  logic [31:1]   set_mask;
  logic [31:1]   clr_mask;

  // ---------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------
  assign lu_ready   = rst_n && !fifo_full;
  assign fifo_push  = lu_valid && lu_ready;
  assign push_entry = '{rd: lu_rd, data: lu_data};

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Arbitration: core first, unless the buffer has been starved long enough,
  // in which case the head is forced out and the core is told to hold.
  // ---------------------------------------------------------------------
  assign stall_o  = rst_n && (starve_cnt == SW'(STARVE_MAX)) && !fifo_empty;
  assign core_win = wb_valid && !stall_o;
  assign fifo_pop = rst_n && !fifo_empty && !core_win;

  // x0 writes are dropped on both paths; an x0 entry is still popped.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (rst_n) begin
      if (core_win) begin
        rf_we    = (wb_rd != '0);
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end else if (fifo_pop) begin
        rf_we    = (head.rd != '0);
        rf_waddr = head.rd;
        rf_wdata = head.data;
      end
    end
  end

  // Counts arbitrations the buffer lost to the core; any pop restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_pop) begin
      starve_cnt <= '0;
    end else if (!fifo_empty && core_win && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Pending scoreboard. Set is applied after clear so that re-issuing a
  // register in the cycle its previous result retires keeps it pending.
  // ---------------------------------------------------------------------
  assign set_mask = iss_valid ? rd_mask(iss_rd) : '0;
  assign clr_mask = fifo_pop  ? rd_mask(head.rd) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  // Bit 0 is hard-wired low so x0 is never reported busy. No bypass of a
  // same-cycle retirement: the query sees registered state only.
  assign pend_vec = {pending, 1'b0};
  assign busy_rs1 = pend_vec[chk_rs1];
  assign busy_rs2 = pend_vec[chk_rs2];
  assign busy_rd  = pend_vec[chk_rd];

  // ---------------------------------------------------------------------
  // Protocol checks on the surrounding pipeline
  // ---------------------------------------------------------------------
  a_core_writes_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (core_win && wb_rd != '0) |-> !pend_vec[wb_rd]);

  // Re-issue is legal only in the cycle the earlier result for it retires.
  a_issue_to_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (iss_valid && iss_rd != '0) |-> (!pend_vec[iss_rd] || (fifo_pop && head.rd == iss_rd)));

  a_lu_not_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_push && lu_rd != '0) |-> pend_vec[lu_rd]);

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  chk_rs1 = '0;
  logic [4:0]  chk_rs2 = '0;
  logic [4:0]  chk_rd = '0;
  logic        busy_rs1, busy_rs2, busy_rd;
  logic        stall_o;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rd(busy_rd),
    .stall_o(stall_o),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  c1, c2, c3;
  } stim_t;

  typedef struct packed {
    logic        cmpb;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        lur;
    logic        b1, b2, b3;
  } exp_t;

  exp_t      expq[$];
  // Reference model: in-order result queue, starvation counter, pending set.
  wb_entry_t mq[$];
  int        starve = 0;
  bit        pend[32];

  int n_cmp = 0;
  int n_bad = 0;
  bit g_acc, g_stl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("rf_we", 32'(rf_we), 32'(e.we));
        check("stall_o", 32'(stall_o), 32'(e.stall));
        check("lu_ready", 32'(lu_ready), 32'(e.lur));
        if (e.we) begin
          check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
          check("rf_wdata", rf_wdata, e.wdata);
        end
        if (e.cmpb) begin
          check("busy_rs1", 32'(busy_rs1), 32'(e.b1));
          check("busy_rs2", 32'(busy_rs2), 32'(e.b2));
          check("busy_rd", 32'(busy_rd), 32'(e.b3));
        end
      end
    end
  end

  // Drive one cycle, queue the expected outputs, then advance the model.
  task automatic step(input stim_t s);
    exp_t      e;
    bit        cw, pop;
    wb_entry_t h;
    @(posedge clk);
    #1;
    rst_n = s.r; wb_valid = s.wv; wb_rd = s.wrd; wb_data = s.wdat;
    lu_valid = s.lv; lu_rd = s.lrd; lu_data = s.ldat;
    iss_valid = s.iv; iss_rd = s.ird;
    chk_rs1 = s.c1; chk_rs2 = s.c2; chk_rd = s.c3;

    e = '0;
    e.lur   = s.r && (mq.size() < DEPTH);
    e.stall = s.r && (starve == SMAX) && (mq.size() > 0);
    cw  = s.wv && !e.stall;
    pop = s.r && (mq.size() > 0) && !cw;
    if (s.r && cw) begin
      e.we = (s.wrd != 0); e.waddr = s.wrd; e.wdata = s.wdat;
    end else if (pop) begin
      h = mq[0];
      e.we = (h.rd != 0); e.waddr = h.rd; e.wdata = h.data;
    end
    e.cmpb = s.r;
    e.b1 = pend[s.c1];
    e.b2 = pend[s.c2];
    e.b3 = pend[s.c3];
    expq.push_back(e);
    g_acc = s.lv && e.lur;
    g_stl = e.stall;

    if (!s.r) begin
      mq.delete();
      starve = 0;
      foreach (pend[i]) pend[i] = 1'b0;
    end else begin
      if (pop) begin
        h = mq.pop_front();
        starve = 0;
        if (h.rd != 0) pend[h.rd] = 1'b0;
      end else if (mq.size() > 0 && cw && starve < SMAX) begin
        starve++;
      end
      if (g_acc) begin
        h.rd = s.lrd; h.data = s.ldat;
        mq.push_back(h);
      end
      if (s.iv && s.ird != 0) pend[s.ird] = 1'b1;
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    s.r  = 1'b1;
    s.c1 = 5'($urandom_range(0, 31));
    s.c2 = 5'($urandom_range(0, 31));
    s.c3 = 5'($urandom_range(0, 31));
    return s;
  endfunction

  function automatic logic [4:0] pick_free();
    logic [4:0] r;
    for (int t = 0; t < 16; t++) begin
      r = 5'($urandom_range(0, 31));
      if (!pend[r]) return r;
    end
    return 5'd0;
  endfunction

  task automatic run_random(input int n);
    stim_t       s;
    bit          last_stl = 0, hold_wv = 0;
    logic [4:0]  hold_wrd = '0, lu_r = '0, r5;
    logic [31:0] hold_wdat = '0, lu_d = '0;
    bit          lu_v = 0, got;
    logic [4:0]  out_q[$];
    for (int k = 0; k < n; k++) begin
      s = idle_s();
      if (last_stl && hold_wv) begin
        s.wv = 1'b1; s.wrd = hold_wrd; s.wdat = hold_wdat;
      end else if ($urandom_range(0, 99) < 55) begin
        s.wv = 1'b1; s.wrd = pick_free(); s.wdat = $urandom();
      end
      if (!lu_v) begin
        if (out_q.size() > 0 && $urandom_range(0, 99) < 45) begin
          lu_v = 1; lu_r = out_q.pop_front(); lu_d = $urandom();
        end else if ($urandom_range(0, 99) < 4) begin
          lu_v = 1; lu_r = 5'd0; lu_d = $urandom();
        end
      end
      s.lv = lu_v; s.lrd = lu_r; s.ldat = lu_d;
      if (out_q.size() < 6 && $urandom_range(0, 99) < 35) begin
        got = 0;
        for (int t = 0; t < 8; t++) begin
          r5 = 5'($urandom_range(1, 31));
          if (!got && !pend[r5] && !(s.wv && s.wrd == r5)) begin
            s.iv = 1'b1; s.ird = r5; got = 1;
          end
        end
      end
      step(s);
      if (g_acc) lu_v = 0;
      if (s.iv) out_q.push_back(s.ird);
      last_stl = g_stl; hold_wv = s.wv; hold_wrd = s.wrd; hold_wdat = s.wdat;
    end
  endtask

  initial begin
    stim_t       s;
    int          li;
    logic [31:0] wd;

    // Reset with junk on every input: no write, no ready, no stall.
    for (int k = 0; k < 3; k++) begin
      s = idle_s(); s.r = 1'b0; s.wv = 1'b1; s.wrd = 5'd4; s.wdat = $urandom();
      s.lv = 1'b1; s.lrd = 5'd6; s.iv = 1'b1; s.ird = 5'd8;
      step(s);
    end

    // Core write with empty buffer.
    s = idle_s(); s.wv = 1'b1; s.wrd = 5'd5; s.wdat = 32'hDEADBEEF; step(s);
    step(idle_s());

    // Issue x7, LU result for x7 with the core idle.
    s = idle_s(); s.iv = 1'b1; s.ird = 5'd7; s.c3 = 5'd7; step(s);
    s = idle_s(); s.lv = 1'b1; s.lrd = 5'd7; s.ldat = 32'h12345678; s.c3 = 5'd7; step(s);
    for (int k = 0; k < 3; k++) begin
      s = idle_s(); s.c3 = 5'd7; step(s);
    end

    // Three LU results against a core writing every cycle.
    for (int k = 0; k < 3; k++) begin
      s = idle_s(); s.iv = 1'b1; s.ird = 5'(10 + k); step(s);
    end
    li = 0; wd = $urandom();
    for (int k = 0; k < 20; k++) begin
      s = idle_s(); s.wv = 1'b1; s.wrd = 5'd3;
      if (!g_stl) wd = $urandom();
      s.wdat = wd;
      if (li < 3) begin
        s.lv = 1'b1; s.lrd = 5'(10 + li); s.ldat = 32'hA0000000 + 32'(li);
      end
      s.c1 = 5'd10; s.c2 = 5'd11; s.c3 = 5'd12;
      step(s);
      if (g_acc) li++;
    end
    step(idle_s());

    // LU result to x0.
    s = idle_s(); s.lv = 1'b1; s.lrd = 5'd0; s.ldat = 32'h55AA55AA; s.c1 = 5'd0; step(s);
    s = idle_s(); s.c1 = 5'd0; step(s);
    step(idle_s());

    // Re-issue of x9 in the cycle its earlier result retires.
    s = idle_s(); s.iv = 1'b1; s.ird = 5'd9; step(s);
    s = idle_s(); s.lv = 1'b1; s.lrd = 5'd9; s.ldat = 32'h09090909; step(s);
    s = idle_s(); s.iv = 1'b1; s.ird = 5'd9; s.c3 = 5'd9; step(s);
    s = idle_s(); s.c3 = 5'd9; s.lv = 1'b1; s.lrd = 5'd9; s.ldat = 32'h90909090; step(s);
    s = idle_s(); s.c3 = 5'd9; step(s);
    s = idle_s(); s.c3 = 5'd9; step(s);

    // Reset with two buffered results.
    s = idle_s(); s.iv = 1'b1; s.ird = 5'd20; step(s);
    s = idle_s(); s.iv = 1'b1; s.ird = 5'd21; s.wv = 1'b1; s.wrd = 5'd3; s.wdat = 32'h1;
    s.lv = 1'b1; s.lrd = 5'd20; s.ldat = 32'h20202020; step(s);
    s = idle_s(); s.wv = 1'b1; s.wrd = 5'd3; s.wdat = 32'h2;
    s.lv = 1'b1; s.lrd = 5'd21; s.ldat = 32'h21212121; step(s);
    s = idle_s(); s.wv = 1'b1; s.wrd = 5'd3; s.wdat = 32'h3; step(s);
    for (int k = 0; k < 2; k++) begin
      s = idle_s(); s.r = 1'b0; step(s);
    end
    for (int k = 0; k < 3; k++) begin
      s = idle_s(); s.c1 = 5'd20; s.c2 = 5'd21; step(s);
    end

    // Randomised traffic, a mid-run reset, then more traffic.
    run_random(1500);
    for (int k = 0; k < 2; k++) begin
      s = idle_s(); s.r = 1'b0; s.wv = 1'b1; s.wrd = 5'd1; step(s);
    end
    run_random(1500);
    for (int k = 0; k < 4; k++) step(idle_s());

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
